// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle integer multiply/divide for the execute stage.
// Shift-add multiply and restoring divide, one bit per clock. Operands are
// reduced to magnitudes at accept so both datapaths run unsigned; signs are
// re-applied in the FIX state, which also handles divide-by-zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_q;      // |rs| (multiplicand / dividend magnitude)
  logic [WIDTH-1:0] b_q;      // |rt| (divisor magnitude)
  logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits then quotient

  // Magnitude of an operand when the op treats it as signed, else raw.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && v[WIDTH-1]) r = -v;
    else                         r = v;
    return r;
  endfunction

  logic               op_signed;
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, raw_a;
  logic               dbz;

  assign op_signed = ~op[0];
  assign is_div    = op_q[1];

  // Per-iteration arithmetic and the final sign correction.
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + {1'b0, a_q};
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, b_q};
    div_borrow = div_diff[WIDTH+1];
    if (sign_a ^ sign_b) prod_fix = -{acc_hi, acc_lo};
    else                 prod_fix = {acc_hi, acc_lo};
    if (sign_a ^ sign_b) quot_fix = -acc_lo;
    else                 quot_fix = acc_lo;
    if (sign_a) begin
      rem_fix = -acc_hi;
      raw_a   = -a_q;
    end else begin
      rem_fix = acc_hi;
      raw_a   = a_q;
    end
    dbz = is_div && (b_q == {WIDTH{1'b0}});
  end

  // Next-state logic for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
               else       state_next = IDLE;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
               else                     state_next = RUN;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= {CW{1'b0}};
      op_q        <= 2'b00;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_hi      <= {WIDTH{1'b0}};
      acc_lo      <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= op_signed & rs_data[WIDTH-1];
            sign_b <= op_signed & rt_data[WIDTH-1];
            a_q    <= mag(rs_data, op_signed);
            b_q    <= mag(rt_data, op_signed);
            acc_hi <= {WIDTH{1'b0}};
            // Divide shifts the dividend out of acc_lo; multiply consumes multiplier bits.
            if (op[1]) acc_lo <= mag(rs_data, op_signed);
            else       acc_lo <= mag(rt_data, op_signed);
            cnt    <= {CW{1'b0}};
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_borrow) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (acc_lo[0]) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
              acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dbz;
          if (dbz) begin
            lo <= {WIDTH{1'b1}};
            hi <= raw_a;
          end else if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
